// File: rtl/display_frame_scheduler_pkg.sv
// display_frame_scheduler_pkg: frame geometry, scheduler FSM states and frame buffer type shared with the matrix driver
package display_frame_scheduler_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_SWAP} state_t;
  typedef logic [ROWS-1:0][COLS-1:0] frame_t;
endpackage

// File: rtl/display_frame_scheduler_arb.sv
// rr_arbiter2: two-requester round-robin pick with a registered pointer
// Ports: clk, reset (async, active-high), req[1:0] {ovl, game}, upd/upd_idx
// (end of a grant and who held it), pick (0 = game, 1 = ovl; valid when |req).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       pick
);
  logic ptr;
  // ptr names the requester favoured on contention; a lone request always wins
  always_comb pick = &req ? ptr : req[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= 1'b0;
    else if (upd) ptr <= ~upd_idx;
endmodule

// File: rtl/display_frame_scheduler.sv
// display_frame_scheduler: arbitrates two frame writers into a back buffer and swaps it to the front on frame_end
// Ports: clk, reset (async, active-high); req_game/req_ovl in, gnt_game/gnt_ovl out;
// write beat wr_valid/wr_row/wr_data/wr_last with wr_ready; frame_end pulse from the
// driver; disp_rows (front buffer), swap_pending, frame_cnt.
// Option: FRAME_BLINK_EN adds blink_req, blanking disp_rows while frame_cnt[3] is set.
module display_frame_scheduler
  import display_frame_scheduler_pkg::*;
#(
  parameter int ROWS   = display_frame_scheduler_pkg::ROWS,
  parameter int COLS   = display_frame_scheduler_pkg::COLS,
  parameter int FCNT_W = 7
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef FRAME_BLINK_EN
  input  logic                       blink_req,
`endif
  input  logic                       req_game,
  input  logic                       req_ovl,
  output logic                       gnt_game,
  output logic                       gnt_ovl,
  input  logic                       wr_valid,
  input  logic [2:0]                 wr_row,
  input  logic [COLS-1:0]            wr_data,
  input  logic                       wr_last,
  output logic                       wr_ready,
  input  logic                       frame_end,
  output logic [ROWS-1:0][COLS-1:0]  disp_rows,
  output logic                       swap_pending,
  output logic [FCNT_W-1:0]          frame_cnt
);
  state_t state;
  logic [ROWS-1:0][COLS-1:0] back, front;
  logic gnt_req, upd, pick;
  always_comb gnt_req = gnt_ovl ? req_ovl : req_game;
  // the pointer moves whenever a grant ends: abort or completed swap
  always_comb upd = (state == GRANT && !gnt_req && !(wr_valid && wr_last)) ||
                    (state == WAIT_SWAP && frame_end);
  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req_ovl, req_game}),
    .upd     (upd),
    .upd_idx (gnt_ovl),
    .pick    (pick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= IDLE;
      back         <= '0;
      front        <= '0;
      gnt_game     <= 1'b0;
      gnt_ovl      <= 1'b0;
      wr_ready     <= 1'b0;
      swap_pending <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (frame_end) frame_cnt <= frame_cnt + 1'b1;
      case (state)
        IDLE:
          if (req_game || req_ovl) begin
            gnt_game <= !pick;
            gnt_ovl  <= pick;
            wr_ready <= 1'b1;
            state    <= GRANT;
          end
        GRANT: begin
          if (wr_valid) back[wr_row] <= wr_data;
          // a frame_end on the wr_last edge is ignored here: the swap needs a later one
          if (wr_valid && wr_last) begin
            state        <= WAIT_SWAP;
            swap_pending <= 1'b1;
            wr_ready     <= 1'b0;
          end else if (!gnt_req) begin
            state    <= IDLE;
            gnt_game <= 1'b0;
            gnt_ovl  <= 1'b0;
            wr_ready <= 1'b0;
          end
        end
        WAIT_SWAP:
          if (frame_end) begin
            front        <= back;
            swap_pending <= 1'b0;
            gnt_game     <= 1'b0;
            gnt_ovl      <= 1'b0;
            state        <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef FRAME_BLINK_EN
  always_comb disp_rows = (blink_req && frame_cnt[3]) ? '0 : front;
`else
  always_comb disp_rows = front;
`endif
endmodule
